// File: rtl/cp0_exc_ctrl.sv
// Coprocessor-0 exception/interrupt controller: SR, Cause and EPC, with req/EPC for the pipeline.
// Optional Count/Compare timer is enabled by defining CP0_TIMER_EN.
`timescale 1ns/1ps
module cp0_exc_ctrl #(
    parameter int HW_INT_W     = 6,
    parameter bit EXL_ON_RESET = 1'b0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [HW_INT_W-1:0] hw_int,
    input  logic [31:0]         m_pc,
    input  logic                m_bd,
    input  logic [4:0]          m_exc,
    input  logic                m_eret,
    input  logic                we,
    input  logic [4:0]          addr,
    input  logic [31:0]         wdata,
    output logic [31:0]         rdata,
    output logic                req,
    output logic [31:0]         epc_out
);

    localparam logic [4:0]  ADDR_COUNT   = 5'd9;
    localparam logic [4:0]  ADDR_COMPARE = 5'd11;
    localparam logic [4:0]  ADDR_SR      = 5'd12;
    localparam logic [4:0]  ADDR_CAUSE   = 5'd13;
    localparam logic [4:0]  ADDR_EPC     = 5'd14;
    localparam logic [4:0]  ADDR_PRID    = 5'd15;
    localparam logic [31:0] PRID_VALUE   = 32'h0000_7C07;

    logic [5:0]  im_q, im_d;
    logic        exl_q, exl_d;
    logic        ie_q, ie_d;
    logic        bd_q, bd_d;
    logic [5:0]  ip_q, ip_d;
    logic [4:0]  exccode_q, exccode_d;
    logic [31:0] epc_q, epc_d;

    logic [5:0]  hw_ip_s;
    logic [5:0]  ip_view_s;
    logic [31:0] sr_s;
    logic [31:0] cause_s;
    logic        int_req_s;
    logic        exc_req_s;
    logic        req_s;
    logic        wr_s;

    // External lines are fitted onto the six IP bits regardless of HW_INT_W.
    generate
        if (HW_INT_W >= 6) begin : g_ip_trunc
            assign hw_ip_s = hw_int[5:0];
        end else begin : g_ip_pad
            assign hw_ip_s = {{(6-HW_INT_W){1'b0}}, hw_int};
        end
    endgenerate

`ifdef CP0_TIMER_EN
    logic [31:0] count_q, count_d;
    logic [31:0] compare_q, compare_d;
    logic        timer_pend_q, timer_pend_d;

    assign ip_view_s = ip_q | {timer_pend_q, 5'b00000};
`else
    assign ip_view_s = ip_q;
`endif

    assign sr_s    = {16'h0000, im_q, 8'h00, exl_q, ie_q};
    assign cause_s = {bd_q, 15'h0000, ip_view_s, 3'b000, exccode_q, 2'b00};

    // req is masked while in reset and while EXL is set.
    assign int_req_s = ie_q & ~exl_q & (|(ip_view_s & im_q));
    assign exc_req_s = (m_exc != 5'd0) & ~exl_q;
    assign req_s     = ~reset & (int_req_s | exc_req_s);
    assign wr_s      = we & ~req_s;
    assign req       = req_s;

    assign epc_out = (we && (addr == ADDR_EPC)) ? wdata : epc_q;

    // Next-state for SR, Cause and EPC.
    always_comb begin
        im_d      = im_q;
        exl_d     = exl_q;
        ie_d      = ie_q;
        bd_d      = bd_q;
        exccode_d = exccode_q;
        epc_d     = epc_q;
        ip_d      = hw_ip_s;
        if (req_s) begin
            exl_d     = 1'b1;
            bd_d      = m_bd;
            exccode_d = int_req_s ? 5'd0 : m_exc;
            epc_d     = m_bd ? (m_pc - 32'd4) : m_pc;
        end else begin
            if (m_eret) begin
                exl_d = 1'b0;
            end else if (wr_s && (addr == ADDR_SR)) begin
                exl_d = wdata[1];
            end else begin
                exl_d = exl_q;
            end
            if (wr_s && (addr == ADDR_SR)) begin
                im_d = wdata[15:10];
                ie_d = wdata[0];
            end else begin
                im_d = im_q;
                ie_d = ie_q;
            end
            if (wr_s && (addr == ADDR_EPC)) begin
                epc_d = wdata;
            end else begin
                epc_d = epc_q;
            end
        end
    end

    // State registers for SR, Cause and EPC.
    always_ff @(posedge clk) begin
        if (reset) begin
            im_q      <= 6'd0;
            exl_q     <= EXL_ON_RESET;
            ie_q      <= 1'b0;
            bd_q      <= 1'b0;
            ip_q      <= 6'd0;
            exccode_q <= 5'd0;
            epc_q     <= 32'd0;
        end else begin
            im_q      <= im_d;
            exl_q     <= exl_d;
            ie_q      <= ie_d;
            bd_q      <= bd_d;
            ip_q      <= ip_d;
            exccode_q <= exccode_d;
            epc_q     <= epc_d;
        end
    end

`ifdef CP0_TIMER_EN
    // Count/Compare next-state; a Compare write clears the pending tick.
    always_comb begin
        count_d      = count_q + 32'd1;
        compare_d    = compare_q;
        timer_pend_d = timer_pend_q;
        if (wr_s && (addr == ADDR_COUNT)) begin
            count_d = wdata;
        end else begin
            count_d = count_q + 32'd1;
        end
        if (wr_s && (addr == ADDR_COMPARE)) begin
            compare_d    = wdata;
            timer_pend_d = 1'b0;
        end else if ((count_q == compare_q) && (compare_q != 32'd0)) begin
            timer_pend_d = 1'b1;
        end else begin
            timer_pend_d = timer_pend_q;
        end
    end

    // Timer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q      <= 32'd0;
            compare_q    <= 32'd0;
            timer_pend_q <= 1'b0;
        end else begin
            count_q      <= count_d;
            compare_q    <= compare_d;
            timer_pend_q <= timer_pend_d;
        end
    end
`endif

    // mfc0 read decode.
    always_comb begin
        rdata = 32'd0;
        case (addr)
            ADDR_SR:      rdata = sr_s;
            ADDR_CAUSE:   rdata = cause_s;
            ADDR_EPC:     rdata = epc_q;
            ADDR_PRID:    rdata = PRID_VALUE;
`ifdef CP0_TIMER_EN
            ADDR_COUNT:   rdata = count_q;
            ADDR_COMPARE: rdata = compare_q;
`endif
            default:      rdata = 32'd0;
        endcase
    end

endmodule
